// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl -- trap / interrupt sequencer in front of csr_reg's write port.
//
// Takes ecall / ebreak / mret / external IRQ from the ex stage, holds the
// pipeline and walks a small Moore FSM. That FSM writes mepc, mcause and
// mstatus one per cycle and then redirects the PC. For mret it restores
// mstatus and jumps to mepc.
//
// Optional feature macro: TRAP_TIMER_EN
//   When it is defined, a 64-bit mtime counter and an mtimecmp register are
//   added. They raise a lowest-priority timer interrupt (cause CAUSE_TMR).
//   When it is undefined, mtimecmp_we_i and mtimecmp_i are ignored.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   inst_valid_i      ex holds a valid instruction
//   inst_addr_i       PC of the ex instruction
//   ecall_i/ebreak_i/mret_i   ex instruction decode
//   irq_i             external interrupt, level-sensitive
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i/csr_mie_i   current CSR values
//   mtimecmp_we_i/mtimecmp_i  mtimecmp write (timer build only)
//   csr_we_o/csr_waddr_o/csr_wdata_o   CSR write port
//   hold_o            stall IF/ID/EX
//   jump_o/jump_addr_o  one-cycle PC redirect
//   dbg_state_o       current FSM state (debug)
//
// Handshake: inst_valid_i qualifies the ex-stage event, and hold_o acts as
// the inverse of ready. An event is consumed in the IDLE cycle where
// inst_valid_i=1 and hold_o rises. While hold_o=1 outside IDLE, the ex
// contents are frozen and anything presented there is ignored.
// ----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] CAUSE_ECALL = XLEN'(32'd11),
    parameter logic [XLEN-1:0] CAUSE_EBRK  = XLEN'(32'd3),
    parameter logic [XLEN-1:0] CAUSE_EXT   = XLEN'(32'h8000_000B),
    parameter logic [XLEN-1:0] CAUSE_TMR   = XLEN'(32'h8000_0007)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            mret_i,
    input  logic            irq_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mie_i,
    input  logic            mtimecmp_we_i,
    input  logic [XLEN-1:0] mtimecmp_i,
    output logic            csr_we_o,
    output logic [31:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            hold_o,
    output logic            jump_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_MEPC   = 3'd1,
        S_W_MCAUSE = 3'd2,
        S_W_MSTAT  = 3'd3,
        S_JUMP     = 3'd4,
        S_R_MSTAT  = 3'd5,
        S_JUMP_R   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, cause_q, cause_d;
    logic            trap_go, mret_go;
    logic            ext_pend, tmr_pend;
    logic            unused_bits;

    assign ext_pend = irq_i & csr_mie_i[11] & csr_mstatus_i[3];

`ifdef TRAP_TIMER_EN
    logic [63:0]     mtime_q;
    logic [XLEN-1:0] mtimecmp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q <= mtime_q + 64'd1;
            if (mtimecmp_we_i) mtimecmp_q <= mtimecmp_i;
        end
    end

    assign tmr_pend    = (mtime_q[XLEN-1:0] >= mtimecmp_q) & csr_mie_i[7] & csr_mstatus_i[3];
    assign unused_bits = ^{mtime_q, csr_mie_i, csr_mtvec_i[1:0]};
`else
    assign tmr_pend    = 1'b0;
    assign unused_bits = ^{mtimecmp_we_i, mtimecmp_i, CAUSE_TMR, csr_mie_i, csr_mtvec_i[1:0]};
`endif

    // Event selection in IDLE. Lower-priority events in the same cycle are
    // dropped. This is gated by rst so that hold_o stays 0 during reset.
    always_comb begin
        trap_go = 1'b0;
        mret_go = 1'b0;
        cause_d = cause_q;
        if (rst && inst_valid_i && state_q == S_IDLE) begin
            if (ecall_i) begin
                trap_go = 1'b1;
                cause_d = CAUSE_ECALL;
            end else if (ebreak_i) begin
                trap_go = 1'b1;
                cause_d = CAUSE_EBRK;
            end else if (mret_i) begin
                mret_go = 1'b1;
            end else if (ext_pend) begin
                trap_go = 1'b1;
                cause_d = CAUSE_EXT;
            end else if (tmr_pend) begin
                trap_go = 1'b1;
`ifdef TRAP_TIMER_EN
                cause_d = CAUSE_TMR;
`endif
            end
        end
    end

    // State register plus the latched PC and cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap_go || mret_go) pc_q <= inst_addr_i;
            if (trap_go) cause_q <= cause_d;
        end
    end

    // Next-state logic. Undefined encodings fall back to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (trap_go)      state_d = S_W_MEPC;
                else if (mret_go) state_d = S_R_MSTAT;
                else              state_d = S_IDLE;
            end
            S_W_MEPC:   state_d = S_W_MCAUSE;
            S_W_MCAUSE: state_d = S_W_MSTAT;
            S_W_MSTAT:  state_d = S_JUMP;
            S_JUMP:     state_d = S_IDLE;
            S_R_MSTAT:  state_d = S_JUMP_R;
            S_JUMP_R:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore outputs. The only exception is hold_o in IDLE, which must stall
    // ex in the same cycle the event is accepted.
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = 32'h0;
        csr_wdata_o = '0;
        hold_o      = 1'b1;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        case (state_q)
            S_IDLE: hold_o = trap_go | mret_go;
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h341;
                csr_wdata_o = pc_q;
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h342;
                csr_wdata_o = cause_q;
            end
            S_W_MSTAT: begin
                // The old MIE is saved into MPIE, and MIE is cleared.
                csr_we_o       = 1'b1;
                csr_waddr_o    = 32'h300;
                csr_wdata_o    = csr_mstatus_i;
                csr_wdata_o[7] = csr_mstatus_i[3];
                csr_wdata_o[3] = 1'b0;
            end
            S_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = {csr_mtvec_i[XLEN-1:2], 2'b00};
            end
            S_R_MSTAT: begin
                // MIE is restored from MPIE, and MPIE is set.
                csr_we_o       = 1'b1;
                csr_waddr_o    = 32'h300;
                csr_wdata_o    = csr_mstatus_i;
                csr_wdata_o[3] = csr_mstatus_i[7];
                csr_wdata_o[7] = 1'b1;
            end
            S_JUMP_R: begin
                jump_o      = 1'b1;
                jump_addr_o = csr_mepc_i;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule
